// File: rtl/pmb_telemetry_snap_if.sv
// -----------------------------------------------------------------------------
// pmb_telemetry_snap_if
// Byte-read bus of the PMB telemetry block.
//   rd_en    : byte read strobe (host -> block)
//   rd_addr  : byte address, sampled when rd_en=1 (host -> block)
//   rd_data  : registered read data (block -> host)
//   rd_ack   : one-cycle acknowledge, one cycle after rd_en (block -> host)
// The host side uses the master modport, the telemetry block the slave modport.
// -----------------------------------------------------------------------------
interface pmb_telemetry_snap_if #(
   parameter int AWIDTH = 8
) ();

   logic              rd_en;
   logic [AWIDTH-1:0] rd_addr;
   logic [7:0]        rd_data;
   logic              rd_ack;

   modport master (
      output rd_en,
      output rd_addr,
      input  rd_data,
      input  rd_ack
   );

   modport slave (
      input  rd_en,
      input  rd_addr,
      output rd_data,
      output rd_ack
   );

endinterface

// File: rtl/pmb_telemetry_snap.sv
// -----------------------------------------------------------------------------
// pmb_telemetry_snap
// Captures NCHAN post-processed ADC channel values, tracks a per-channel peak,
// keeps sticky new-data / overrun flags and serves all of it over a registered
// byte-read port. Reading a low byte latches the matching high byte into a
// shadow register so a multi-byte value is always read coherently.
//
// Ports:
//   wr_clk     : clock
//   reset      : asynchronous, active-low reset
//   ch_data    : packed channel values, channel k at [k*DWIDTH +: DWIDTH]
//   ch_valid   : per-channel one-cycle update strobe
//   pk_clr     : per-channel peak clear strobe
//   rd_bus     : byte-read bus (rd_en, rd_addr, rd_data, rd_ack), slave side
//   new_flags  : sticky new-data flags (register outputs)
//   ovr_flags  : sticky overrun flags (register outputs)
//
// Byte map, offsets from BASE_ADDR, channel k:
//   4k+0 live[7:0] (loads live shadow), 4k+1 live shadow,
//   4k+2 peak[7:0] (loads peak shadow), 4k+3 peak shadow,
//   4*NCHAN new_flags (clear-on-read), 4*NCHAN+1 ovr_flags (clear-on-read).
// -----------------------------------------------------------------------------
module pmb_telemetry_snap #(
   parameter int          NCHAN     = 6,
   parameter int          DWIDTH    = 11,
   parameter int unsigned BASE_ADDR = 8'h98,
   parameter int          AWIDTH    = 8
) (
   input  logic                    wr_clk,
   input  logic                    reset,
   input  logic [NCHAN*DWIDTH-1:0] ch_data,
   input  logic [NCHAN-1:0]        ch_valid,
   input  logic [NCHAN-1:0]        pk_clr,
   pmb_telemetry_snap_if.slave     rd_bus,
   output logic [NCHAN-1:0]        new_flags,
   output logic [NCHAN-1:0]        ovr_flags
);

   localparam logic [AWIDTH-1:0] BASE_A  = AWIDTH'(BASE_ADDR);
   localparam logic [AWIDTH-1:0] NEW_OFS = AWIDTH'(4 * NCHAN);
   localparam logic [AWIDTH-1:0] OVR_OFS = AWIDTH'(4 * NCHAN + 1);

   // Upper bits of a channel value, zero-extended to one byte.
   function automatic logic [7:0] hi_byte(input logic [DWIDTH-1:0] value);
      hi_byte = 8'(value >> 8);
   endfunction

   // Low byte of a channel value.
   function automatic logic [7:0] lo_byte(input logic [DWIDTH-1:0] value);
      lo_byte = value[7:0];
   endfunction

   logic [DWIDTH-1:0] live_r        [NCHAN];
   logic [DWIDTH-1:0] peak_r        [NCHAN];
   logic [7:0]        shadow_live_r [NCHAN];
   logic [7:0]        shadow_pk_r   [NCHAN];
   logic [DWIDTH-1:0] slice_s       [NCHAN];
   logic [NCHAN-1:0]  new_r;
   logic [NCHAN-1:0]  ovr_r;
   logic [NCHAN-1:0]  new_nxt_s;
   logic [NCHAN-1:0]  ovr_nxt_s;
   logic [7:0]        rd_data_r;
   logic              rd_ack_r;

   logic [AWIDTH-1:0] offset_s;
   logic              rd_hit_s;
   logic [7:0]        rd_byte_s;
   logic [NCHAN-1:0]  live_lo_rd_s;
   logic [NCHAN-1:0]  live_hi_rd_s;
   logic [NCHAN-1:0]  pk_lo_rd_s;
   logic [NCHAN-1:0]  pk_hi_rd_s;
   logic              new_rd_s;
   logic              ovr_rd_s;

   // The lower-bound compare guards against the subtraction wrapping for
   // addresses below the map.
   assign offset_s = rd_bus.rd_addr - BASE_A;
   assign rd_hit_s = rd_bus.rd_en && (rd_bus.rd_addr >= BASE_A);

   // Address decode and read-data AND-OR mux; out-of-map reads select nothing.
   always_comb begin
      rd_byte_s    = 8'h00;
      live_lo_rd_s = '0;
      live_hi_rd_s = '0;
      pk_lo_rd_s   = '0;
      pk_hi_rd_s   = '0;
      new_rd_s     = rd_hit_s && (offset_s == NEW_OFS);
      ovr_rd_s     = rd_hit_s && (offset_s == OVR_OFS);
      for (int k = 0; k < NCHAN; k++) begin
         live_lo_rd_s[k] = rd_hit_s && (offset_s == AWIDTH'(4 * k));
         live_hi_rd_s[k] = rd_hit_s && (offset_s == AWIDTH'(4 * k + 1));
         pk_lo_rd_s[k]   = rd_hit_s && (offset_s == AWIDTH'(4 * k + 2));
         pk_hi_rd_s[k]   = rd_hit_s && (offset_s == AWIDTH'(4 * k + 3));
         rd_byte_s = rd_byte_s
                   | ({8{live_lo_rd_s[k]}} & lo_byte(live_r[k]))
                   | ({8{live_hi_rd_s[k]}} & shadow_live_r[k])
                   | ({8{pk_lo_rd_s[k]}}   & lo_byte(peak_r[k]))
                   | ({8{pk_hi_rd_s[k]}}   & shadow_pk_r[k]);
      end
      rd_byte_s = rd_byte_s
                | ({8{new_rd_s}} & 8'(new_r))
                | ({8{ovr_rd_s}} & 8'(ovr_r));
   end

   // Flag next-state: a new sample always sets new_flags, even over a
   // clear-on-read; overrun only when an unread sample is overwritten.
   always_comb begin
      new_nxt_s = ch_valid | (new_r & ~{NCHAN{new_rd_s}});
      ovr_nxt_s = (ch_valid & new_r & ~{NCHAN{new_rd_s}})
                | (ovr_r & ~{NCHAN{ovr_rd_s}});
   end

   // Sticky flag registers.
   always_ff @(posedge wr_clk or negedge reset) begin
      if (!reset) begin
         new_r <= '0;
         ovr_r <= '0;
      end else begin
         new_r <= new_nxt_s;
         ovr_r <= ovr_nxt_s;
      end
   end

   // Registered read port; a read in flight is dropped by reset.
   always_ff @(posedge wr_clk or negedge reset) begin
      if (!reset) begin
         rd_data_r <= 8'h00;
         rd_ack_r  <= 1'b0;
      end else begin
         rd_ack_r <= rd_bus.rd_en;
         if (rd_bus.rd_en) begin
            rd_data_r <= rd_byte_s;
         end
      end
   end

   for (genvar k = 0; k < NCHAN; k++) begin : g_chan
      assign slice_s[k] = ch_data[k*DWIDTH +: DWIDTH];

      // Live value and peak; a same-cycle update overrides a peak clear.
      always_ff @(posedge wr_clk or negedge reset) begin
         if (!reset) begin
            live_r[k] <= '0;
            peak_r[k] <= '0;
         end else begin
            if (ch_valid[k]) begin
               live_r[k] <= slice_s[k];
               if (pk_clr[k] || (slice_s[k] > peak_r[k])) begin
                  peak_r[k] <= slice_s[k];
               end
            end else if (pk_clr[k]) begin
               peak_r[k] <= '0;
            end
         end
      end

      // Shadows latch the pre-update value, matching the low byte returned.
      always_ff @(posedge wr_clk or negedge reset) begin
         if (!reset) begin
            shadow_live_r[k] <= 8'h00;
            shadow_pk_r[k]   <= 8'h00;
         end else begin
            if (live_lo_rd_s[k]) begin
               shadow_live_r[k] <= hi_byte(live_r[k]);
            end
            if (pk_lo_rd_s[k]) begin
               shadow_pk_r[k] <= hi_byte(peak_r[k]);
            end
         end
      end
   end

   assign rd_bus.rd_data = rd_data_r;
   assign rd_bus.rd_ack  = rd_ack_r;
   assign new_flags      = new_r;
   assign ovr_flags      = ovr_r;

endmodule

// File: tb/tb_pmb_telemetry_snap.sv
// -----------------------------------------------------------------------------
// tb_pmb_telemetry_snap
// Directed, table-driven bench for pmb_telemetry_snap (NCHAN=6, DWIDTH=11,
// BASE_ADDR=8'h98), plus hand-written multi-cycle sequences for same-cycle
// collisions, back-to-back reads and reset during a read.
// -----------------------------------------------------------------------------
module tb_pmb_telemetry_snap;

   localparam int NCHAN  = 6;
   localparam int DWIDTH = 11;
   localparam int AWIDTH = 8;

   typedef enum logic [1:0] {OP_UPD = 2'd0, OP_RD = 2'd1, OP_CLR = 2'd2} op_e;

   typedef struct {
      op_e         op;
      int          ch;
      logic [10:0] data;
      logic        clr;
      logic [7:0]  addr;
      logic [7:0]  exp_data;
      logic [5:0]  exp_new;
      logic [5:0]  exp_ovr;
   } vec_t;

   logic                    wr_clk = 1'b0;
   logic                    reset;
   logic [NCHAN*DWIDTH-1:0] ch_data;
   logic [NCHAN-1:0]        ch_valid;
   logic [NCHAN-1:0]        pk_clr;
   logic [NCHAN-1:0]        new_flags;
   logic [NCHAN-1:0]        ovr_flags;

   int   n_chk  = 0;
   int   n_fail = 0;
   vec_t vecs[$];

   pmb_telemetry_snap_if #(.AWIDTH(AWIDTH)) bus ();

   pmb_telemetry_snap #(
      .NCHAN     (NCHAN),
      .DWIDTH    (DWIDTH),
      .BASE_ADDR (8'h98),
      .AWIDTH    (AWIDTH)
   ) dut (
      .wr_clk    (wr_clk),
      .reset     (reset),
      .ch_data   (ch_data),
      .ch_valid  (ch_valid),
      .pk_clr    (pk_clr),
      .rd_bus    (bus),
      .new_flags (new_flags),
      .ovr_flags (ovr_flags)
   );

   always #5 wr_clk = ~wr_clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic add(input op_e op, input int ch, input logic [10:0] data, input logic clr,
                      input logic [7:0] addr, input logic [7:0] exp_data,
                      input logic [5:0] exp_new, input logic [5:0] exp_ovr);
      vec_t v;
      v.op = op; v.ch = ch; v.data = data; v.clr = clr; v.addr = addr;
      v.exp_data = exp_data; v.exp_new = exp_new; v.exp_ovr = exp_ovr;
      vecs.push_back(v);
   endtask

   task automatic drive_ch(input int ch, input logic [10:0] data);
      ch_data[ch*DWIDTH +: DWIDTH] = data;
      ch_valid[ch] = 1'b1;
   endtask

   task automatic idle_inputs();
      ch_valid    = '0;
      pk_clr      = '0;
      bus.rd_en   = 1'b0;
   endtask

   // One isolated read: drive at negedge, check #1 after the capturing edge.
   task automatic read_chk(input string name, input logic [7:0] addr, input logic [7:0] exp);
      @(negedge wr_clk);
      bus.rd_en   = 1'b1;
      bus.rd_addr = addr;
      @(posedge wr_clk);
      #1;
      bus.rd_en = 1'b0;
      chk({name, "_data"}, 32'(bus.rd_data), 32'(exp));
      chk({name, "_ack"}, 32'(bus.rd_ack), 32'd1);
   endtask

   task automatic upd(input int ch, input logic [10:0] data);
      @(negedge wr_clk);
      drive_ch(ch, data);
      @(posedge wr_clk);
      #1;
      idle_inputs();
   endtask

   initial begin
      reset       = 1'b0;
      ch_data     = '0;
      idle_inputs();
      bus.rd_addr = 8'h00;

      // Vector table (flags columns give the state after each row).
      add(OP_UPD, 2, 11'h5A3, 1'b0, 8'h00, 8'h00, 6'h04, 6'h00);
      add(OP_RD,  0, 11'h000, 1'b0, 8'hA0, 8'hA3, 6'h04, 6'h00);
      add(OP_UPD, 2, 11'h1FF, 1'b0, 8'h00, 8'h00, 6'h04, 6'h04);
      add(OP_RD,  0, 11'h000, 1'b0, 8'hA1, 8'h05, 6'h04, 6'h04);
      add(OP_RD,  0, 11'h000, 1'b0, 8'hA0, 8'hFF, 6'h04, 6'h04);
      add(OP_RD,  0, 11'h000, 1'b0, 8'hA1, 8'h01, 6'h04, 6'h04);
      add(OP_UPD, 0, 11'd100, 1'b0, 8'h00, 8'h00, 6'h05, 6'h04);
      add(OP_UPD, 0, 11'd300, 1'b0, 8'h00, 8'h00, 6'h05, 6'h05);
      add(OP_UPD, 0, 11'd200, 1'b0, 8'h00, 8'h00, 6'h05, 6'h05);
      add(OP_RD,  0, 11'h000, 1'b0, 8'h9A, 8'h2C, 6'h05, 6'h05);
      add(OP_RD,  0, 11'h000, 1'b0, 8'h9B, 8'h01, 6'h05, 6'h05);
      add(OP_RD,  0, 11'h000, 1'b0, 8'h98, 8'hC8, 6'h05, 6'h05);
      add(OP_RD,  0, 11'h000, 1'b0, 8'h99, 8'h00, 6'h05, 6'h05);
      add(OP_CLR, 0, 11'h000, 1'b1, 8'h00, 8'h00, 6'h05, 6'h05);
      add(OP_RD,  0, 11'h000, 1'b0, 8'h9A, 8'h00, 6'h05, 6'h05);
      add(OP_RD,  0, 11'h000, 1'b0, 8'h9B, 8'h00, 6'h05, 6'h05);
      add(OP_UPD, 0, 11'd50,  1'b1, 8'h00, 8'h00, 6'h05, 6'h05);
      add(OP_RD,  0, 11'h000, 1'b0, 8'h9A, 8'h32, 6'h05, 6'h05);
      add(OP_RD,  0, 11'h000, 1'b0, 8'h9B, 8'h00, 6'h05, 6'h05);
      add(OP_RD,  0, 11'h000, 1'b0, 8'hB0, 8'h05, 6'h00, 6'h05);
      add(OP_RD,  0, 11'h000, 1'b0, 8'hB1, 8'h05, 6'h00, 6'h00);
      add(OP_UPD, 4, 11'h123, 1'b0, 8'h00, 8'h00, 6'h10, 6'h00);
      add(OP_UPD, 4, 11'h124, 1'b0, 8'h00, 8'h00, 6'h10, 6'h10);
      add(OP_RD,  0, 11'h000, 1'b0, 8'hB0, 8'h10, 6'h00, 6'h10);
      add(OP_RD,  0, 11'h000, 1'b0, 8'hB0, 8'h00, 6'h00, 6'h10);
      add(OP_RD,  0, 11'h000, 1'b0, 8'hB1, 8'h10, 6'h00, 6'h00);
      add(OP_RD,  0, 11'h000, 1'b0, 8'hB1, 8'h00, 6'h00, 6'h00);
      add(OP_UPD, 3, 11'h0AA, 1'b0, 8'h00, 8'h00, 6'h08, 6'h00);
      add(OP_RD,  0, 11'h000, 1'b0, 8'h97, 8'h00, 6'h08, 6'h00);
      add(OP_RD,  0, 11'h000, 1'b0, 8'hB2, 8'h00, 6'h08, 6'h00);
      add(OP_RD,  0, 11'h000, 1'b0, 8'h00, 8'h00, 6'h08, 6'h00);
      add(OP_RD,  0, 11'h000, 1'b0, 8'hFF, 8'h00, 6'h08, 6'h00);
      add(OP_RD,  0, 11'h000, 1'b0, 8'hA4, 8'hAA, 6'h08, 6'h00);
      add(OP_RD,  0, 11'h000, 1'b0, 8'hA5, 8'h00, 6'h08, 6'h00);
      add(OP_RD,  0, 11'h000, 1'b0, 8'hB0, 8'h08, 6'h00, 6'h00);

      // Reset state
      repeat (3) @(posedge wr_clk);
      #1;
      chk("rst_rd_data", 32'(bus.rd_data), 32'h0);
      chk("rst_rd_ack",  32'(bus.rd_ack),  32'h0);
      chk("rst_new",     32'(new_flags),   32'h0);
      chk("rst_ovr",     32'(ovr_flags),   32'h0);
      @(negedge wr_clk);
      reset = 1'b1;

      // Every mapped address reads zero after reset
      for (int a = 8'h98; a <= 8'hB1; a++) begin
         read_chk($sformatf("rst_map_%0h", a), 8'(a), 8'h00);
      end
      @(posedge wr_clk);
      #1;
      chk("ack_one_cycle", 32'(bus.rd_ack), 32'h0);

      // Table-driven vectors
      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge wr_clk);
         case (vecs[i].op)
            OP_UPD: begin
               drive_ch(vecs[i].ch, vecs[i].data);
               pk_clr[vecs[i].ch] = vecs[i].clr;
            end
            OP_CLR: pk_clr[vecs[i].ch] = 1'b1;
            OP_RD: begin
               bus.rd_en   = 1'b1;
               bus.rd_addr = vecs[i].addr;
            end
            default: ;
         endcase
         @(posedge wr_clk);
         #1;
         idle_inputs();
         if (vecs[i].op == OP_RD) begin
            chk($sformatf("vec%0d_data", i), 32'(bus.rd_data), 32'(vecs[i].exp_data));
            chk($sformatf("vec%0d_ack", i),  32'(bus.rd_ack),  32'd1);
         end
         chk($sformatf("vec%0d_new", i), 32'(new_flags), 32'(vecs[i].exp_new));
         chk($sformatf("vec%0d_ovr", i), 32'(ovr_flags), 32'(vecs[i].exp_ovr));
      end

      // rd_data holds while idle
      @(posedge wr_clk);
      #1;
      chk("hold_data", 32'(bus.rd_data), 32'h08);
      chk("hold_ack",  32'(bus.rd_ack),  32'h0);

      // Flag read colliding with a ch_valid on a channel already flagged
      upd(1, 11'h011);
      @(negedge wr_clk);
      bus.rd_en   = 1'b1;
      bus.rd_addr = 8'hB0;
      drive_ch(1, 11'h022);
      @(posedge wr_clk);
      #1;
      idle_inputs();
      chk("coll_data", 32'(bus.rd_data), 32'h02);
      chk("coll_new",  32'(new_flags),   32'h02);
      chk("coll_ovr",  32'(ovr_flags),   32'h00);

      // Low-byte read in the same cycle as an update of that channel
      upd(5, 11'h3AB);
      @(negedge wr_clk);
      bus.rd_en   = 1'b1;
      bus.rd_addr = 8'hAC;
      drive_ch(5, 11'h455);
      @(posedge wr_clk);
      #1;
      idle_inputs();
      chk("lo_coll_data", 32'(bus.rd_data), 32'hAB);
      chk("lo_coll_ovr",  32'(ovr_flags),   32'h20);
      read_chk("lo_coll_hi_old", 8'hAD, 8'h03);
      read_chk("lo_coll_lo_new", 8'hAC, 8'h55);
      read_chk("lo_coll_hi_new", 8'hAD, 8'h04);

      // Back-to-back reads
      @(negedge wr_clk);
      bus.rd_en   = 1'b1;
      bus.rd_addr = 8'hA0;
      @(posedge wr_clk);
      #1;
      chk("b2b0_data", 32'(bus.rd_data), 32'hFF);
      chk("b2b0_ack",  32'(bus.rd_ack),  32'h1);
      bus.rd_addr = 8'hB1;
      @(posedge wr_clk);
      #1;
      bus.rd_en = 1'b0;
      chk("b2b1_data", 32'(bus.rd_data), 32'h20);
      chk("b2b1_ack",  32'(bus.rd_ack),  32'h1);
      @(posedge wr_clk);
      #1;
      chk("b2b_ack_low", 32'(bus.rd_ack),  32'h0);
      chk("b2b_hold",    32'(bus.rd_data), 32'h20);
      chk("b2b_ovr_clr", 32'(ovr_flags),   32'h00);

      // Reset in the cycle after a read
      read_chk("pre_rst", 8'hAC, 8'h55);
      #2;
      reset = 1'b0;
      #1;
      chk("midrst_data", 32'(bus.rd_data), 32'h0);
      chk("midrst_ack",  32'(bus.rd_ack),  32'h0);
      chk("midrst_new",  32'(new_flags),   32'h0);
      // A read requested while reset is held is dropped
      @(negedge wr_clk);
      bus.rd_en   = 1'b1;
      bus.rd_addr = 8'hB0;
      @(posedge wr_clk);
      #1;
      chk("inrst_ack", 32'(bus.rd_ack), 32'h0);
      @(negedge wr_clk);
      bus.rd_en = 1'b0;
      reset     = 1'b1;
      @(posedge wr_clk);
      #1;
      chk("postrst_ack", 32'(bus.rd_ack), 32'h0);
      read_chk("postrst_live", 8'hAC, 8'h00);
      read_chk("postrst_shadow", 8'hA1, 8'h00);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
